serial_stream_tx: RTL and testbench
===================================

SERIAL_STREAM_TX -- requirements
Module: serial_stream_tx

Interface
REQ-001 The module SHALL have exactly one clock; reset SHALL be asynchronous and active-high, with ports named clk and rst.
REQ-002 The module SHALL have these ports: clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 load_valid  in  1  frame offered on load_data/load_len.
REQ-005 load_ready  out  1  module can accept a frame this cycle.
REQ-006 load_data  in  32  frame bits, right-justified; bit load_len-1 is sent first.
REQ-007 load_len  in  6  frame length in bits; legal range 1..32.
REQ-008 stall  in  1  pause shifting while high.
REQ-009 bit_out  out  1  serial data bit, MSB-first.
REQ-010 bit_valid  out  1  bit_out is a valid stream bit this cycle; drives a receiver's enable.
REQ-011 busy  out  1  a frame is in progress (SHIFT or GAP).
REQ-012 frame_done  out  1  one-cycle pulse after the last bit of a frame.
REQ-013 len_err  out  1  one-cycle pulse when an illegal length is offered and accepted.
REQ-014 bits_sent  out  16  total count of valid bits emitted since reset.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and GAP.
REQ-016 load_ready SHALL be 1 only in IDLE while rst is low.
REQ-017 A frame SHALL be accepted on a rising edge where load_valid and load_ready are both 1; the module SHALL capture load_data and load_len on that edge.
REQ-018 On acceptance of a length from 1 to 32, the FSM SHALL move to SHIFT, and bit_out SHALL equal load_data[load_len-1] with bit_valid=1 in the very next cycle (one-cycle latency).
REQ-019 In SHIFT with stall=0, each cycle SHALL present one bit with bit_valid=1, descending from index len-1 to index 0.
REQ-020 In SHIFT with stall=1, bit_valid SHALL be 0, bit_out SHALL hold its value, and the bit index SHALL NOT advance; the held bit SHALL be emitted once stall drops.
REQ-021 After bit 0 has been emitted with bit_valid=1, the FSM SHALL enter GAP for exactly one cycle, with bit_valid=0, bit_out=0 and frame_done=1, and then return to IDLE.
REQ-022 stall SHALL have no effect in IDLE or GAP.
REQ-023 An accepted load_len of 0, or of 33 to 63, SHALL assert len_err for one cycle, emit no bits, and keep the FSM in IDLE.
REQ-024 load_valid while load_ready=0 SHALL be ignored; the frame in progress SHALL NOT be modified.
REQ-025 bit_out SHALL be 0 whenever the FSM is in IDLE.
REQ-026 busy SHALL be 1 exactly in SHIFT and GAP.
REQ-027 bits_sent SHALL increment by 1 on every cycle where bit_valid=1, and SHALL wrap from 65535 to 0 without any flag.
REQ-028 A length-1 frame SHALL produce one valid bit followed immediately by the GAP cycle.
REQ-029 Back-to-back frames SHALL be separated by exactly GAP plus one IDLE cycle when load_valid is held high.

Reset
REQ-030 Asserting rst at any time, including mid-frame, SHALL immediately force IDLE, discard the frame in progress, and set bit_out=0, bit_valid=0, busy=0, frame_done=0, len_err=0, bits_sent=0 and load_ready=0.
REQ-031 load_ready SHALL rise to 1 on the first clock edge after rst deasserts.
REQ-032 No frame_done SHALL be generated for a frame aborted by reset.

Verification
REQ-033 Load 0x355, len 10 -> bits 1101010101 on consecutive cycles with bit_valid=1, then frame_done one cycle later; bits_sent=10.
REQ-034 Load 0x9, len 4 with stall high for 2 cycles after the second bit -> stream 1,0,(hold),(hold),0,1; bit_valid low during the stall; bits_sent=4.
REQ-035 Load with len 0, then with len 40 -> len_err pulses twice, no bit_valid, busy stays 0, bits_sent unchanged.
REQ-036 rst asserted on the 5th bit of a 10-bit frame -> all outputs zero immediately; no frame_done; after release, a new len 3 frame of 0x5 -> 101.
REQ-037 load_valid held high with two frames (len 1, then len 2 of 0x2) -> 1, GAP, IDLE, 1, 0, GAP; load_data changes during SHIFT are ignored.
REQ-038 Preload bits_sent near wrap by sending 2048 frames of 32 bits -> bits_sent reads 0 after the 65536th valid bit.

Source files
------------

// File: rtl/serial_stream_tx.sv
// serial_stream_tx
//   Shifts a right-justified frame of 1..32 bits out MSB-first, one bit per
//   cycle, with a stall input that freezes the bit position. Each frame is
//   followed by a single GAP cycle that pulses frame_done.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   load_valid  frame offered on load_data/load_len
//   load_ready  frame can be accepted this cycle (IDLE, after reset release)
//   load_data   32-bit frame, bit load_len-1 sent first
//   load_len    frame length in bits, legal 1..32
//   stall       freezes shifting while high (SHIFT only)
//   bit_out     serial data bit
//   bit_valid   bit_out carries a stream bit this cycle
//   busy        frame in progress (SHIFT or GAP)
//   frame_done  one-cycle pulse in the GAP cycle after the last bit
//   len_err     one-cycle pulse after an illegal length was accepted
//   bits_sent   free-running count of valid bits since reset (wraps)
module serial_stream_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic [5:0]  load_len,
  input  logic        stall,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        busy,
  output logic        frame_done,
  output logic        len_err,
  output logic [15:0] bits_sent
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] data_reg;
  logic [4:0]  idx_reg, idx_next;
  logic        ready_en_reg;
  logic        len_err_reg;
  logic [15:0] bits_sent_reg;
  logic        accept;
  logic        len_ok;

  // ready_en_reg holds load_ready low until the first edge after reset
  // release, so a frame can never be accepted in the release cycle.
  assign load_ready = (state_reg == IDLE) && ready_en_reg;
  assign accept     = load_valid && load_ready;
  assign len_ok     = (load_len != 6'd0) && (load_len <= 6'd32);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    bit_out    = 1'b0;
    bit_valid  = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept && len_ok) begin
          state_next = SHIFT;
          // len 32 truncates to 0; 0 - 1 wraps to 31, the MSB index.
          idx_next   = load_len[4:0] - 5'd1;
        end
      end
      SHIFT: begin
        busy      = 1'b1;
        bit_out   = data_reg[idx_reg];
        bit_valid = !stall;
        if (!stall) begin
          if (idx_reg == 5'd0) begin
            state_next = GAP;
          end else begin
            idx_next = idx_reg - 5'd1;
          end
        end
      end
      GAP: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      data_reg      <= 32'd0;
      idx_reg       <= 5'd0;
      ready_en_reg  <= 1'b0;
      len_err_reg   <= 1'b0;
      bits_sent_reg <= 16'd0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      ready_en_reg <= 1'b1;
      len_err_reg  <= accept && !len_ok;
      if (accept) begin
        data_reg <= load_data;
      end
      if (bit_valid) begin
        bits_sent_reg <= bits_sent_reg + 16'd1;
      end
    end
  end

  assign len_err   = len_err_reg;
  assign bits_sent = bits_sent_reg;

endmodule

// File: tb/tb_serial_stream_tx.sv
module tb_serial_stream_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic [5:0]  load_len;
  logic        stall;
  logic        bit_out;
  logic        bit_valid;
  logic        busy;
  logic        frame_done;
  logic        len_err;
  logic [15:0] bits_sent;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] exp_bits;

  serial_stream_tx dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_len   (load_len),
    .stall      (stall),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .frame_done (frame_done),
    .len_err    (len_err),
    .bits_sent  (bits_sent)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk1({tag, "_busy"},  busy, 1'b0);
    chk1({tag, "_valid"}, bit_valid, 1'b0);
    chk1({tag, "_bit"},   bit_out, 1'b0);
    chk1({tag, "_done"},  frame_done, 1'b0);
    chk1({tag, "_ready"}, load_ready, 1'b1);
    chk16({tag, "_count"}, bits_sent, exp_bits);
  endtask

  task automatic all_zero_chk(input string tag);
    chk1({tag, "_ready"}, load_ready, 1'b0);
    chk1({tag, "_busy"},  busy, 1'b0);
    chk1({tag, "_valid"}, bit_valid, 1'b0);
    chk1({tag, "_bit"},   bit_out, 1'b0);
    chk1({tag, "_done"},  frame_done, 1'b0);
    chk1({tag, "_lerr"},  len_err, 1'b0);
    chk16({tag, "_count"}, bits_sent, 16'd0);
  endtask

  // Starts at a negedge in IDLE, ends at the negedge that begins the IDLE
  // cycle after GAP. Expected stream is a queue of bits built MSB-first.
  task automatic send_frame(input logic [31:0] data, input int len, input bit rnd,
                            input int stall_k, input int stall_n, input bit hold);
    bit q[$];
    int held = 0;
    int k    = 0;
    int cyc  = 0;
    bit s;
    for (int i = len - 1; i >= 0; i--) q.push_back(data[i]);
    load_valid = 1'b1;
    load_data  = data;
    load_len   = len[5:0];
    stall      = rnd ? 1'($urandom_range(1, 0)) : 1'b0;
    #1;
    chk1("accept_ready", load_ready, 1'b1);
    chk1("accept_busy", busy, 1'b0);
    @(negedge clk);
    if (!hold) load_valid = 1'b0;
    while (q.size() > 0 && cyc < 4 * len + 20) begin
      load_data = $urandom;
      load_len  = 6'($urandom_range(63, 0));
      if (k == stall_k && held < stall_n) begin
        s = 1'b1;
        held++;
      end else if (rnd) begin
        s = ($urandom_range(3, 0) == 0);
      end else begin
        s = 1'b0;
      end
      stall = s;
      #1;
      chk1("shift_valid", bit_valid, !s);
      chk1("shift_bit", bit_out, q[0]);
      chk1("shift_busy", busy, 1'b1);
      chk1("shift_done", frame_done, 1'b0);
      chk1("shift_ready", load_ready, 1'b0);
      chk16("shift_count", bits_sent, exp_bits);
      if (!s) begin
        void'(q.pop_front());
        k++;
        exp_bits++;
      end
      cyc++;
      @(negedge clk);
    end
    chk1("frame_timeout", q.size() == 0, 1'b1);
    stall = rnd ? 1'($urandom_range(1, 0)) : 1'b0;
    #1;
    chk1("gap_valid", bit_valid, 1'b0);
    chk1("gap_bit", bit_out, 1'b0);
    chk1("gap_done", frame_done, 1'b1);
    chk1("gap_busy", busy, 1'b1);
    chk1("gap_ready", load_ready, 1'b0);
    chk16("gap_count", bits_sent, exp_bits);
    @(negedge clk);
    stall = 1'b0;
  endtask

  // Starts and ends at a negedge in IDLE.
  task automatic bad_len(input int len);
    load_valid = 1'b1;
    load_data  = $urandom;
    load_len   = len[5:0];
    stall      = 1'b0;
    #1;
    chk1("bad_ready", load_ready, 1'b1);
    @(negedge clk);
    load_valid = 1'b0;
    #1;
    chk1("bad_lerr", len_err, 1'b1);
    chk1("bad_busy", busy, 1'b0);
    chk1("bad_valid", bit_valid, 1'b0);
    chk16("bad_count", bits_sent, exp_bits);
    @(negedge clk);
    #1;
    chk1("bad_lerr_clear", len_err, 1'b0);
    idle_chk("bad_idle");
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] tmp;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 32'd0;
    load_len   = 6'd0;
    stall      = 1'b0;
    exp_bits   = 16'd0;
    #1;
    all_zero_chk("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("ready_before_edge", load_ready, 1'b0);
    @(negedge clk);
    #1;
    idle_chk("after_reset");
    @(negedge clk);

    // 0x355 len 10 -> 1101010101
    send_frame(32'h355, 10, 1'b0, -1, 0, 1'b0);
    #1;
    chk16("r033_count", bits_sent, 16'd10);
    idle_chk("r033_idle");
    @(negedge clk);

    // 0x9 len 4, stall 2 cycles after the second bit
    send_frame(32'h9, 4, 1'b0, 2, 2, 1'b0);
    #1;
    chk16("r034_count", bits_sent, 16'd14);
    @(negedge clk);

    // illegal lengths
    bad_len(0);
    bad_len(40);

    // randomized legal frames with random stalls, plus random illegal lengths
    for (int n = 0; n < 10; n++) begin
      send_frame($urandom, $urandom_range(32, 1), 1'b1, -1, 0, 1'b0);
      if ($urandom_range(1, 0) == 1) bad_len($urandom_range(63, 33));
    end
    bad_len(32 + 1);
    send_frame($urandom, 32, 1'b1, -1, 0, 1'b0);
    send_frame($urandom, 1, 1'b1, -1, 0, 1'b0);

    // reset during the 5th bit of a 10-bit frame
    tmp        = 32'h2AB;
    load_valid = 1'b1;
    load_data  = tmp;
    load_len   = 6'd10;
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("pre_reset_bit", bit_out, tmp[9 - i]);
      chk1("pre_reset_valid", bit_valid, 1'b1);
      exp_bits++;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    all_zero_chk("mid_reset");
    exp_bits = 16'd0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("release_ready", load_ready, 1'b0);
    chk1("release_done", frame_done, 1'b0);
    @(negedge clk);
    #1;
    idle_chk("post_release");
    @(negedge clk);
    send_frame(32'h5, 3, 1'b0, -1, 0, 1'b0);

    // back-to-back with load_valid held high
    send_frame(32'h1, 1, 1'b0, -1, 0, 1'b1);
    send_frame(32'h2, 2, 1'b0, -1, 0, 1'b1);
    load_valid = 1'b0;
    #1;
    idle_chk("b2b_idle");
    chk16("b2b_count", bits_sent, 16'd6);
    @(negedge clk);

    // counter wrap: 2048 frames of 32 bits from a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    exp_bits = 16'd0;
    @(negedge clk);
    for (int n = 0; n < 2048; n++) begin
      send_frame($urandom, 32, 1'b0, -1, 0, 1'b0);
    end
    #1;
    chk16("wrap_zero", bits_sent, 16'd0);
    chk1("wrap_idle_ready", load_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
